handshake_muli_fixp_sat: RTL and testbench

//  Elastic signed fixed-point multiplier; consumes a handshake_constant coefficient (rhs) and a data token (lhs).

---
 rtl/handshake_fixp_pkg.sv | 16 +
 rtl/handshake_join_2.sv | 13 +
 rtl/handshake_muli_fixp_sat.sv | 74 +++++++
 tb/tb_handshake_muli_fixp_sat.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_fixp_pkg.sv
// handshake_fixp_pkg: fixed-point saturation bounds, rounding bias and Q-format conversion helpers.
package handshake_fixp_pkg;
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction
  function automatic longint round_bias(input int frac);
    return longint'(1) <<< (frac - 1);
  endfunction
  // Converts the ratio num/den to a Q-format integer with frac fractional bits.
  function automatic longint to_q(input int num, input int den, input int frac);
    return (longint'(num) <<< frac) / den;
  endfunction
endpackage

// File: rtl/handshake_join_2.sv
// handshake_join_2: two-input valid/ready join; both tokens are consumed together or not at all.
module handshake_join_2 (
  input  logic a_valid_i,
  input  logic b_valid_i,
  input  logic ready_i,
  output logic a_ready_o,
  output logic b_ready_o,
  output logic fire_o
);
  assign a_ready_o = b_valid_i & ready_i;
  assign b_ready_o = a_valid_i & ready_i;
  assign fire_o    = a_valid_i & b_valid_i & ready_i;
endmodule

// File: rtl/handshake_muli_fixp_sat.sv
// handshake_muli_fixp_sat: elastic three-stage signed fixed-point multiplier with optional rounding and saturation.
module handshake_muli_fixp_sat import handshake_fixp_pkg::*; #(
  parameter int DATA_WIDTH = 15,
  parameter int FRAC_BITS  = 13,
  parameter int ROUND      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] lhs,
  input  logic                  lhs_valid,
  output logic                  lhs_ready,
  input  logic [DATA_WIDTH-1:0] rhs,
  input  logic                  rhs_valid,
  output logic                  rhs_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  input  logic                  result_ready
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int RW = PW + 1;
  localparam logic signed [RW-1:0] SMAX = RW'(sat_max(DATA_WIDTH));
  localparam logic signed [RW-1:0] SMIN = RW'(sat_min(DATA_WIDTH));
  localparam logic signed [RW-1:0] BIAS = (ROUND != 0) ? RW'(round_bias(FRAC_BITS)) : '0;
  logic in_ready, fire, adv1, adv2, adv3;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic signed [PW-1:0] p_q, p_d;
  logic signed [RW-1:0] r, s;
  handshake_join_2 u_join (
    .a_valid_i (lhs_valid),
    .b_valid_i (rhs_valid),
    .ready_i   (in_ready),
    .a_ready_o (lhs_ready),
    .b_ready_o (rhs_ready),
    .fire_o    (fire)
  );
  // A stage advances when it holds a token and the next stage is empty or draining.
  assign adv3     = v3_q & result_ready;
  assign adv2     = v2_q & (~v3_q | adv3);
  assign adv1     = v1_q & (~v2_q | adv2);
  assign in_ready = ~v1_q | adv1;
  always_comb begin
    r     = {p_q[PW-1], p_q} + BIAS;
    s     = r >>> FRAC_BITS;
    v1_d  = fire | (v1_q & ~adv1);
    a_d   = fire ? lhs : a_q;
    b_d   = fire ? rhs : b_q;
    v2_d  = adv1 | (v2_q & ~adv2);
    p_d   = adv1 ? a_q * b_q : p_q;
    v3_d  = adv2 | (v3_q & ~adv3);
    res_d = !adv2 ? res_q : (s > SMAX) ? SMAX[DATA_WIDTH-1:0] : (s < SMIN) ? SMIN[DATA_WIDTH-1:0] : s[DATA_WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      res_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      a_q   <= a_d;
      b_q   <= b_d;
      p_q   <= p_d;
      res_q <= res_d;
    end
  end
  assign result       = res_q;
  assign result_valid = v3_q;
endmodule

// File: tb/tb_handshake_muli_fixp_sat.sv
// tb_handshake_muli_fixp_sat: randomized and directed bench for the elastic fixed-point multiplier.
module tb_handshake_muli_fixp_sat;
  localparam int W = 15;
  localparam int F = 13;
  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] lhs, rhs;
  logic lhs_valid, rhs_valid, result_ready;
  logic lhs_ready, rhs_ready, result_valid;
  logic [W-1:0] result;
  logic lhs_ready0, rhs_ready0, result_valid0;
  logic [W-1:0] result0;
  int vectors = 0;
  int miscompares = 0;
  int fires = 0;
  int outs = 0;
  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];
  logic prev_stall = 1'b0;
  logic [W-1:0] prev_res;

  always #5 clk = ~clk;

  handshake_muli_fixp_sat #(.DATA_WIDTH(W), .FRAC_BITS(F), .ROUND(1)) dut (
    .clk(clk), .rst(rst), .lhs(lhs), .lhs_valid(lhs_valid), .lhs_ready(lhs_ready),
    .rhs(rhs), .rhs_valid(rhs_valid), .rhs_ready(rhs_ready),
    .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );
  handshake_muli_fixp_sat #(.DATA_WIDTH(W), .FRAC_BITS(F), .ROUND(0)) dut0 (
    .clk(clk), .rst(rst), .lhs(lhs), .lhs_valid(lhs_valid), .lhs_ready(lhs_ready0),
    .rhs(rhs), .rhs_valid(rhs_valid), .rhs_ready(rhs_ready0),
    .result(result0), .result_valid(result_valid0), .result_ready(result_ready)
  );

  // Real-number semantics: product, optional +half, floor-divide by 2^F, clamp to W-bit range.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input bit rnd);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    if (rnd) p = p + (longint'(1) <<< (F - 1));
    p = p >>> F;
    if (p > 16383) p = 16383;
    if (p < -16384) p = -16384;
    return p[W-1:0];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      q1.delete();
      q0.delete();
      prev_stall = 1'b0;
    end else begin
      vectors++;
      if (result_valid0 !== result_valid || lhs_ready0 !== lhs_ready || rhs_ready0 !== rhs_ready) begin
        miscompares++;
        $display("FAIL handshake_sync: round1 v/lr/rr=%b%b%b round0=%b%b%b", result_valid, lhs_ready, rhs_ready,
                 result_valid0, lhs_ready0, rhs_ready0);
      end
      if (prev_stall) begin
        vectors++;
        if (!result_valid || result !== prev_res) begin
          miscompares++;
          $display("FAIL stall_hold: got valid=%b result=%h, need valid=1 result=%h", result_valid, result, prev_res);
        end
      end
      if (result_valid && result_ready) begin
        vectors++;
        outs++;
        if (q1.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_extra: got result=%h with no outstanding token", result);
        end else begin
          logic [W-1:0] e1, e0;
          e1 = q1.pop_front();
          e0 = q0.pop_front();
          if (result !== e1 || result0 !== e0) begin
            miscompares++;
            $display("FAIL scoreboard: got %h/%h (round/trunc), need %h/%h", result, result0, e1, e0);
          end
        end
      end
      if (lhs_valid && rhs_valid && lhs_ready) begin
        fires++;
        q1.push_back(model(lhs, rhs, 1'b1));
        q0.push_back(model(lhs, rhs, 1'b0));
      end
      prev_stall = result_valid && !result_ready;
      prev_res   = result;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    lhs = a;
    rhs = b;
    lhs_valid = 1'b1;
    rhs_valid = 1'b1;
    @(negedge clk);
    while (!lhs_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!lhs_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: lhs_ready=%b after %0d cycles, need 1", lhs_ready, n);
    end
    @(posedge clk);
    #1;
    lhs_valid = 1'b0;
    rhs_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!result_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!result_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL result_timeout: result_valid=%b after %0d cycles, need 1", result_valid, n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (result_valid !== 1'b0 || result !== '0 || lhs_ready !== 1'b0 || rhs_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b result=%h lr=%b rr=%b, need 0 0000 0 0", result_valid, result,
               lhs_ready, rhs_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    result_ready = 1'b1;
    send(15'h2000, 15'h2EEE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (result_valid !== (i == 2)) begin
        miscompares++;
        $display("FAIL basic_latency: cycle %0d after fire valid=%b, need %b", i + 1, result_valid, i == 2);
      end
    end
    vectors++;
    if (result !== 15'h2EEE || result0 !== 15'h2EEE) begin
      miscompares++;
      $display("FAIL basic_value: got %h/%h, need 2eee/2eee", result, result0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    logic [W-1:0] a[3] = '{15'h2EEE, 15'h4000, 15'h4000};
    logic [W-1:0] b[3] = '{15'h2EEE, 15'h2EEE, 15'h4000};
    logic [W-1:0] e[3] = '{15'h3FFF, 15'h4000, 15'h3FFF};
    result_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(a[i], b[i]);
      wait_valid();
      vectors++;
      if (result !== e[i] || result0 !== e[i]) begin
        miscompares++;
        $display("FAIL saturation_%0d: got %h/%h, need %h", i, result, result0, e[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_rounding();
    logic [W-1:0] a[3]  = '{15'h3000, 15'h0003, 15'h7FFD};
    logic [W-1:0] b[3]  = '{15'h1000, 15'h1000, 15'h1000};
    logic [W-1:0] e1[3] = '{15'h1800, 15'h0002, 15'h7FFF};
    logic [W-1:0] e0[3] = '{15'h1800, 15'h0001, 15'h7FFE};
    result_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(a[i], b[i]);
      wait_valid();
      vectors++;
      if (result !== e1[i] || result0 !== e0[i]) begin
        miscompares++;
        $display("FAIL rounding_%0d: got %h/%h (round/trunc), need %h/%h", i, result, result0, e1[i], e0[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_join();
    logic [W-1:0] a, b;
    int seen = 0;
    a = W'($urandom);
    b = W'($urandom);
    result_ready = 1'b1;
    lhs = a;
    rhs = b;
    lhs_valid = 1'b1;
    rhs_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (lhs_ready !== 1'b0 || rhs_ready !== 1'b1 || result_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL join_wait: lr=%b rr=%b valid=%b, need 0 1 0", lhs_ready, rhs_ready, result_valid);
      end
      @(posedge clk);
      #1;
    end
    rhs_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if (lhs_ready !== 1'b1 || rhs_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL join_fire: lr=%b rr=%b, need 1 1", lhs_ready, rhs_ready);
    end
    @(posedge clk);
    #1;
    lhs_valid = 1'b0;
    rhs_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (result_valid) begin
        seen++;
        vectors++;
        if (result !== model(a, b, 1'b1)) begin
          miscompares++;
          $display("FAIL join_value: got %h, need %h", result, model(a, b, 1'b1));
        end
      end
    end
    vectors++;
    if (seen != 1) begin
      miscompares++;
      $display("FAIL join_count: got %0d results, need 1", seen);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a[5], b[5], e[5];
    int sent = 0;
    int got = 0;
    int first = -1;
    int last = -1;
    for (int i = 0; i < 5; i++) begin
      a[i] = W'($urandom);
      b[i] = W'($urandom);
      e[i] = model(a[i], b[i], 1'b1);
    end
    result_ready = 1'b0;
    lhs_valid = 1'b1;
    rhs_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      lhs = a[sent];
      rhs = b[sent];
      @(negedge clk);
      if (lhs_ready) sent++;
      if (result_valid) begin
        vectors++;
        if (result !== e[0]) begin
          miscompares++;
          $display("FAIL bp_stalled_value: got %h, need %h", result, e[0]);
        end
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    vectors++;
    if (sent != 3 || lhs_ready !== 1'b0 || rhs_ready !== 1'b0 || result_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_full: accepted=%0d lr=%b rr=%b valid=%b, need 3 0 0 1", sent, lhs_ready, rhs_ready,
               result_valid);
    end
    @(posedge clk);
    #1;
    result_ready = 1'b1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      lhs_valid = (sent < 5);
      rhs_valid = (sent < 5);
      if (sent < 5) begin
        lhs = a[sent];
        rhs = b[sent];
      end
      @(negedge clk);
      if (result_valid) begin
        vectors++;
        if (result !== e[got]) begin
          miscompares++;
          $display("FAIL bp_order_%0d: got %h, need %h", got, result, e[got]);
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (lhs_valid && lhs_ready) sent++;
      @(posedge clk);
      #1;
    end
    lhs_valid = 1'b0;
    rhs_valid = 1'b0;
    vectors++;
    if (got != 5 || sent != 5 || last - first != 4) begin
      miscompares++;
      $display("FAIL bp_drain: got=%0d sent=%0d span=%0d, need 5 5 4", got, sent, last - first);
    end
  endtask

  task automatic test_reset_midflight();
    result_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (result_valid !== 1'b0 || result !== '0) begin
      miscompares++;
      $display("FAIL reset_async: valid=%b result=%h, need 0 0000", result_valid, result);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    result_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (result_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_stale: cycle %0d valid=%b result=%h, need valid 0", i, result_valid, result);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pick[5] = '{15'h4000, 15'h3FFF, 15'h0000, 15'h0001, 15'h7FFF};
    for (int c = 0; c < 400; c++) begin
      lhs_valid = ($urandom_range(3) != 0);
      rhs_valid = ($urandom_range(3) != 0);
      result_ready = ($urandom_range(2) != 0);
      lhs = ($urandom_range(3) == 0) ? pick[$urandom_range(4)] : W'($urandom);
      rhs = ($urandom_range(3) == 0) ? pick[$urandom_range(4)] : W'($urandom);
      @(posedge clk);
      #1;
    end
    lhs_valid = 1'b0;
    rhs_valid = 1'b0;
    result_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (fires != outs || q1.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_conservation: fired=%0d emitted=%0d pending=%0d, need equal and 0", fires, outs, q1.size());
    end
  endtask

  initial begin
    rst = 1'b0;
    lhs = '0;
    rhs = '0;
    lhs_valid = 1'b0;
    rhs_valid = 1'b0;
    result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_join();
    test_backpressure();
    test_reset_midflight();
    fires = 0;
    outs = 0;
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
